// File: rtl/sbox_share_sequencer.sv
// Shares one LANE_BYTES-wide S-box bank between the round datapath (128-bit SubBytes)
// and key expansion (32-bit SubWord). Optional macro SBOX_SHARE_RR_EN enables round-robin ties.
module sbox_share_sequencer #(
  parameter int LANE_BYTES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    st_req_valid,
  output logic                    st_req_ready,
  input  logic [127:0]            st_req_data,
  output logic                    st_rsp_valid,
  output logic [127:0]            st_rsp_data,
  input  logic                    key_req_valid,
  output logic                    key_req_ready,
  input  logic [31:0]             key_req_word,
  output logic                    key_rsp_valid,
  output logic [31:0]             key_rsp_word,
  output logic [8*LANE_BYTES-1:0] sbox_in,
  input  logic [8*LANE_BYTES-1:0] sbox_out,
  output logic                    busy,
  output logic                    owner
);

  localparam int LW = 8 * LANE_BYTES;
  localparam int NB = 16 / LANE_BYTES;
  localparam logic [1:0] LAST_BEAT = 2'(NB - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ST_RUN  = 2'd1,
    KEY_RUN = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      beat_q, beat_d;
  logic [127:0]    op_q, op_d;
  logic [127:0]    acc_q, acc_d;
  logic            owner_q, owner_d;
  logic            rdy_q, rdy_d;
  logic            busy_q, busy_d;
  logic [LW-1:0]   sbox_in_q, sbox_in_d;
  logic            st_rsp_valid_q, st_rsp_valid_d;
  logic [127:0]    st_rsp_data_q, st_rsp_data_d;
  logic            key_rsp_valid_q, key_rsp_valid_d;
  logic [31:0]     key_rsp_word_q, key_rsp_word_d;
  logic [127:0]    assembled_s;
  logic            key_prio_s;

`ifdef SBOX_SHARE_RR_EN
  // rr_q remembers the last granted owner (1 = key); the other side wins the next tie
  logic            rr_q, rr_d;

  // Tie-break priority from the round-robin flag
  always_comb begin
    key_prio_s = ~rr_q;
  end

  // Round-robin flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end
`else
  // Fixed priority: key expansion always wins a tie
  always_comb begin
    key_prio_s = 1'b1;
  end
`endif

  // Current beat's bank result merged into the partial state
  always_comb begin
    assembled_s = acc_q;
    assembled_s[int'(beat_q) * LW +: LW] = sbox_out;
  end

  // Next-state logic: arbitration, beat stepping, result capture
  always_comb begin
    state_d         = state_q;
    beat_d          = beat_q;
    op_d            = op_q;
    acc_d           = acc_q;
    owner_d         = owner_q;
    st_rsp_valid_d  = 1'b0;
    st_rsp_data_d   = st_rsp_data_q;
    key_rsp_valid_d = 1'b0;
    key_rsp_word_d  = key_rsp_word_q;
`ifdef SBOX_SHARE_RR_EN
    rr_d            = rr_q;
`endif
    case (state_q)
      IDLE: begin
        if (rdy_q && key_req_valid && (!st_req_valid || key_prio_s)) begin
          op_d    = {96'd0, key_req_word};
          owner_d = 1'b1;
          beat_d  = 2'd0;
          state_d = KEY_RUN;
`ifdef SBOX_SHARE_RR_EN
          rr_d    = 1'b1;
`endif
        end else if (rdy_q && st_req_valid) begin
          op_d    = st_req_data;
          owner_d = 1'b0;
          beat_d  = 2'd0;
          acc_d   = 128'd0;
          state_d = ST_RUN;
`ifdef SBOX_SHARE_RR_EN
          rr_d    = 1'b0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      ST_RUN: begin
        acc_d = assembled_s;
        if (beat_q == LAST_BEAT) begin
          // Publish only the complete state so no partial result is ever visible
          st_rsp_data_d  = assembled_s;
          st_rsp_valid_d = 1'b1;
          beat_d         = 2'd0;
          state_d        = DONE;
        end else begin
          beat_d = beat_q + 2'd1;
        end
      end
      KEY_RUN: begin
        key_rsp_word_d  = sbox_out[31:0];
        key_rsp_valid_d = 1'b1;
        state_d         = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered outputs derived from the upcoming state
  always_comb begin
    rdy_d     = (state_d == IDLE);
    busy_d    = (state_d != IDLE);
    sbox_in_d = {LW{1'b0}};
    case (state_d)
      ST_RUN: begin
        sbox_in_d = op_d[int'(beat_d) * LW +: LW];
      end
      KEY_RUN: begin
        sbox_in_d[31:0] = op_d[31:0];
      end
      default: begin
        sbox_in_d = {LW{1'b0}};
      end
    endcase
  end

  // Sequencer state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      beat_q          <= 2'd0;
      op_q            <= 128'd0;
      acc_q           <= 128'd0;
      owner_q         <= 1'b0;
      rdy_q           <= 1'b0;
      busy_q          <= 1'b0;
      sbox_in_q       <= {LW{1'b0}};
      st_rsp_valid_q  <= 1'b0;
      st_rsp_data_q   <= 128'd0;
      key_rsp_valid_q <= 1'b0;
      key_rsp_word_q  <= 32'd0;
    end else begin
      state_q         <= state_d;
      beat_q          <= beat_d;
      op_q            <= op_d;
      acc_q           <= acc_d;
      owner_q         <= owner_d;
      rdy_q           <= rdy_d;
      busy_q          <= busy_d;
      sbox_in_q       <= sbox_in_d;
      st_rsp_valid_q  <= st_rsp_valid_d;
      st_rsp_data_q   <= st_rsp_data_d;
      key_rsp_valid_q <= key_rsp_valid_d;
      key_rsp_word_q  <= key_rsp_word_d;
    end
  end

  assign st_req_ready  = rdy_q;
  assign key_req_ready = rdy_q;
  assign st_rsp_valid  = st_rsp_valid_q;
  assign st_rsp_data   = st_rsp_data_q;
  assign key_rsp_valid = key_rsp_valid_q;
  assign key_rsp_word  = key_rsp_word_q;
  assign sbox_in       = sbox_in_q;
  assign busy          = busy_q;
  assign owner         = owner_q;

endmodule
